tiny_riscv_boot_ctrl: RTL

Boot/run controller for the 8-bit tiny RISC-V core. It accepts a byte-wide command stream and loads instruction memory with a checksum check. It then sequences the core through reset, free-run or single-step, and stops it on halt, abort or watchdog expiry. It is the only block that drives the core's instruction-memory write port and run/reset controls.

---
 rtl/tiny_riscv_pkg.sv | 23 ++
 rtl/tiny_riscv_boot_ctrl_run_watchdog.sv | 31 +++
 rtl/tiny_riscv_boot_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tiny_riscv_pkg.sv
// Shared definitions for the tiny RISC-V core and its boot/run controller:
// memory geometry, command-header opcodes (header bits [7:6]) and the
// controller state encoding exposed on the status port.
package tiny_riscv_pkg;

  localparam int unsigned ADDR_W = 4;  // 16-word instruction memory
  localparam int unsigned DATA_W = 8;  // instruction / command byte

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_CRST  = 3'd3,
    ST_RUN   = 3'd4,
    ST_STEP  = 3'd5
  } state_t;

endpackage

// File: rtl/tiny_riscv_boot_ctrl_run_watchdog.sv
// run_watchdog: clear/enable cycle counter with a terminal-count flag.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count (held while the core is not running)
//   en        : count this cycle
//   expired   : high during the WDOG_CYCLES-th enabled cycle since clr
module run_watchdog #(
  parameter int unsigned WDOG_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(WDOG_CYCLES))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds completed cycles, so the current enabled cycle is number cnt+1.
  assign expired = en && (cnt == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/tiny_riscv_boot_ctrl.sv
// tiny_riscv_boot_ctrl: boot/run controller for the 8-bit tiny RISC-V core.
// Loads instruction memory from a byte command stream (header, N data bytes,
// XOR checksum), then resets, free-runs or single-steps the core.
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/ready/data     : command byte stream (transfer on valid & ready)
//   imem_we/addr/wdata       : registered instruction-memory write port
//   core_run, core_rst       : core advance enable, core pc/register clear
//   core_halted, core_retire : core HALT level, one-pulse-per-retire
//   status                   : current controller state encoding
//   loaded, done, err        : verified program present, halted, sticky error
//   insn_cnt                 : saturating retired-instruction count
module tiny_riscv_boot_ctrl
  import tiny_riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_W,
  parameter int unsigned DATA_WIDTH  = DATA_W,
  parameter int unsigned WDOG_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_run,
  output logic                  core_rst,
  input  logic                  core_halted,
  input  logic                  core_retire,
  output logic [2:0]            status,
  output logic                  loaded,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            insn_cnt
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] idx, n_last;
  logic [DATA_WIDTH-1:0] csum;
  logic [1:0]            op;
  logic                  accept, running, wdog_expired;
  logic                  load_start, data_wr, ck_done, set_err, clr_err, set_done, clr_core;

  assign op        = cmd_data[DATA_WIDTH-1 -: 2];
  assign cmd_ready = (state == ST_IDLE) || (state == ST_LOAD) ||
                     (state == ST_CHECK) || (state == ST_RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign running   = (state == ST_RUN) || (state == ST_STEP);
  assign core_run  = running;
  assign core_rst  = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_CRST);
  assign status    = state;

  run_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!running),
    .en      (running),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Halt is checked before watchdog and abort so it wins any tie.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    data_wr    = 1'b0;
    ck_done    = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    set_done   = 1'b0;
    clr_core   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          clr_err = 1'b1;
          unique case (op)
            CMD_LOAD: begin
              load_start = 1'b1;
              state_next = ST_LOAD;
            end
            CMD_RUN: begin
              if (loaded) state_next = ST_RUN;
              else        set_err    = 1'b1;
            end
            CMD_STEP: begin
              if (loaded) state_next = ST_STEP;
              else        set_err    = 1'b1;
            end
            default: state_next = ST_CRST;
          endcase
        end
      end
      ST_LOAD: begin
        if (accept) begin
          data_wr = 1'b1;
          if (idx == n_last) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          ck_done    = 1'b1;
          set_err    = (cmd_data != csum);
          state_next = ST_IDLE;
        end
      end
      ST_CRST: begin
        clr_core   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (core_halted) begin
          set_done   = 1'b1;
          state_next = ST_IDLE;
        end else if (wdog_expired) begin
          set_err    = 1'b1;
          state_next = ST_IDLE;
        end else if (accept) begin
          if (op == CMD_RESET) state_next = ST_CRST;
          else                 set_err    = 1'b1;
        end
      end
      ST_STEP: begin
        if (core_halted) begin
          set_done   = 1'b1;
          state_next = ST_IDLE;
        end else if (core_retire) begin
          state_next = ST_IDLE;
        end else if (wdog_expired) begin
          set_err    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      n_last     <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      loaded     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      insn_cnt   <= '0;
    end else begin
      imem_we <= data_wr;
      if (load_start) begin
        n_last <= cmd_data[ADDR_WIDTH-1:0];
        idx    <= '0;
        csum   <= '0;
        loaded <= 1'b0;
      end
      if (data_wr) begin
        imem_addr  <= idx;
        imem_wdata <= cmd_data;
        csum       <= csum ^ cmd_data;
        idx        <= idx + 1'b1;
      end
      if (ck_done) loaded <= (cmd_data == csum);

      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;

      if (load_start || clr_core) done <= 1'b0;
      else if (set_done)          done <= 1'b1;

      if (load_start || clr_core)               insn_cnt <= '0;
      else if (core_retire && (insn_cnt != '1)) insn_cnt <= insn_cnt + 1'b1;
    end
  end

endmodule
